// File: rtl/mode4_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mode4_accumulator_if                                      |
// | Brief    : Beat/result bus of the softmax 4-wide accumulation stage. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mode4_accumulator_if #(
   parameter int DATAWIDTH = 16,
   parameter int LEN_W     = 8
);
   logic                 start;
   logic [LEN_W-1:0]     num_chunks;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] inp0;
   logic [DATAWIDTH-1:0] inp1;
   logic [DATAWIDTH-1:0] inp2;
   logic [DATAWIDTH-1:0] inp3;
   logic                 busy;
   logic                 sum_valid;
   logic [DATAWIDTH-1:0] sum_out;

   modport master (
      output start, num_chunks, in_valid, inp0, inp1, inp2, inp3,
      input  in_ready, busy, sum_valid, sum_out
   );

   modport slave (
      input  start, num_chunks, in_valid, inp0, inp1, inp2, inp3,
      output in_ready, busy, sum_valid, sum_out
   );
endinterface
`default_nettype wire

// File: rtl/mode4_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mode4_accumulator                                         |
// | Brief    : Running FP16 sum of a vector, 4 elements per beat.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mode4_accumulator #(
   parameter int DATAWIDTH = 16,
   parameter int LEN_W     = 8
) (
   input  wire logic            clk,
   input  wire logic            reset_n,
   mode4_accumulator_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_cnt;
   logic [DATAWIDTH-1:0] r_acc;
   logic [DATAWIDTH-1:0] r_stage [4];
   logic                 r_stage_vld;
   logic                 w_hs;
   logic                 w_last;
   logic                 w_start_acc;
   logic [DATAWIDTH-1:0] w_acc_nxt;

   // IEEE binary16 add, round-to-nearest-even, subnormals handled.
   function automatic logic [15:0] fp16_add(input logic [15:0] a_in, input logic [15:0] b_in);
      logic [15:0] a, b;
      logic [4:0]  ea, eb, d;
      logic [10:0] ma, mb;
      logic [13:0] xa, xb, mask, m;
      logic [14:0] sum, packed_v;
      logic [5:0]  e;
      logic [3:0]  lz, sh;
      logic        sub, rnd_up, found;
      if (a_in[14:0] >= b_in[14:0]) begin
         a = a_in; b = b_in;
      end else begin
         a = b_in; b = a_in;
      end
      // a holds the larger magnitude, so any NaN/Inf operand lands in a
      if (a[14:10] == 5'h1f) begin
         if (a[9:0] != 10'd0)                                return a | 16'h0200;
         else if (b[14:10] == 5'h1f && (a[15] != b[15]))     return 16'h7e00;
         else                                                return a;
      end
      ea   = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      eb   = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      ma   = {|a[14:10], a[9:0]};
      mb   = {|b[14:10], b[9:0]};
      d    = ea - eb;
      xa   = {ma, 3'b000};
      mask = ~(14'h3fff << d);
      xb   = {mb, 3'b000} >> d;
      xb[0] = xb[0] | (|({mb, 3'b000} & mask));
      sub  = a[15] ^ b[15];
      sum  = sub ? ({1'b0, xa} - {1'b0, xb}) : ({1'b0, xa} + {1'b0, xb});
      if (sum == 15'd0) return {~sub & a[15], 15'd0};
      if (sum[14]) begin
         m = {sum[14:2], sum[1] | sum[0]};
         e = {1'b0, ea} + 6'd1;
      end else begin
         lz    = 4'd0;
         found = 1'b0;
         for (int i = 13; i >= 0; i--) begin
            if (sum[i] && !found) begin
               found = 1'b1;
               lz    = 4'(13 - i);
            end
         end
         sh = ({1'b0, lz} > (ea - 5'd1)) ? 4'(ea - 5'd1) : lz;
         m  = sum[13:0] << sh;
         e  = {1'b0, ea} - {2'b00, sh};
      end
      if (e >= 6'd31) return {a[15], 15'h7c00};
      rnd_up   = m[2] & (m[1] | m[0] | m[3]);
      // Rounding carry ripples into the exponent field, covering subnormal->normal and ->Inf
      packed_v = {(m[13] ? e[4:0] : 5'd0), m[12:3]} + {14'd0, rnd_up};
      return {a[15], packed_v};
   endfunction

   assign w_hs        = bus.in_valid & (r_state == S_ACCUM);
   assign w_last      = w_hs & (r_cnt == r_len - LEN_W'(1));
   assign w_start_acc = bus.start & (r_state == S_IDLE);
   assign w_acc_nxt   = fp16_add(fp16_add(fp16_add(r_stage[0], r_stage[1]),
                                          fp16_add(r_stage[2], r_stage[3])), r_acc);

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = (bus.num_chunks == '0) ? S_DONE : S_ACCUM;
         S_ACCUM: if (w_last) w_state_nxt = S_FLUSH;
         S_FLUSH: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_len       <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_stage_vld <= 1'b0;
         for (int i = 0; i < 4; i++) r_stage[i] <= '0;
      end else if (w_start_acc) begin
         r_len       <= bus.num_chunks;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_stage_vld <= 1'b0;
      end else begin
         if (r_stage_vld) r_acc <= w_acc_nxt;
         if (w_hs) begin
            r_stage[0]  <= bus.inp0;
            r_stage[1]  <= bus.inp1;
            r_stage[2]  <= bus.inp2;
            r_stage[3]  <= bus.inp3;
            r_stage_vld <= 1'b1;
            r_cnt       <= r_cnt + LEN_W'(1);
         end else begin
            r_stage_vld <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (r_state == S_ACCUM);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.sum_valid = (r_state == S_DONE);
   assign bus.sum_out   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mode4_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mode4_accumulator                                      |
// | Brief    : Directed vector bench for mode4_accumulator.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mode4_accumulator;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   mode4_accumulator_if #(.DATAWIDTH(16), .LEN_W(8)) bus ();

   mode4_accumulator #(.DATAWIDTH(16), .LEN_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  n;
      logic [15:0] v0, v1, v2, v3;
      int          gap;
      int          start_at;
      logic [15:0] exp_sum;
   } vec_t;

   vec_t vecs [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      bus.start      = 1'b1;
      bus.num_chunks = v.n;
      step();
      bus.start = 1'b0;
      chk({nm, " busy after start"}, 16'(bus.busy), 16'd1);
      for (int k = 0; k < int'(v.n); k++) begin
         bus.in_valid = 1'b1;
         {bus.inp0, bus.inp1, bus.inp2, bus.inp3} = {v.v0, v.v1, v.v2, v.v3};
         if (k == v.start_at) begin
            bus.start      = 1'b1;
            bus.num_chunks = 8'd1;
         end
         chk({nm, " in_ready beat"}, 16'(bus.in_ready), 16'd1);
         step();
         bus.start = 1'b0;
         if (k != int'(v.n) - 1) begin
            for (int g = 0; g < v.gap; g++) begin
               bus.in_valid = 1'b0;
               step();
               chk({nm, " in_ready bubble"}, 16'(bus.in_ready), 16'd1);
            end
         end
      end
      // in_valid left high through FLUSH/DONE: must not be consumed
      chk({nm, " in_ready flush"}, 16'(bus.in_ready), 16'd0);
      chk({nm, " sum_valid flush"}, 16'(bus.sum_valid), 16'd0);
      step();
      chk({nm, " sum_valid done"}, 16'(bus.sum_valid), 16'd1);
      chk({nm, " sum_out done"}, bus.sum_out, v.exp_sum);
      step();
      bus.in_valid = 1'b0;
      chk({nm, " sum_valid pulse"}, 16'(bus.sum_valid), 16'd0);
      chk({nm, " busy idle"}, 16'(bus.busy), 16'd0);
      chk({nm, " sum_out hold"}, bus.sum_out, v.exp_sum);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vecs[0] = '{8'd4, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 0, -1, 16'h4c00};
      vecs[1] = '{8'd2, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 3, -1, 16'h4400};
      vecs[2] = '{8'd3, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 0,  1, 16'h4a00};
      vecs[3] = '{8'd1, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 0, -1, 16'h4400};
      vecs[4] = '{8'd1, 16'h3c00, 16'h4000, 16'h4200, 16'h4400, 0, -1, 16'h4900};
      vecs[5] = '{8'd2, 16'h3c00, 16'hbc00, 16'h4000, 16'hc000, 1, -1, 16'h0000};
      vecs[6] = '{8'd2, 16'h3c00, 16'h3c00, 16'h3c00, 16'hc400, 0, -1, 16'hc000};
      vecs[7] = '{8'd1, 16'h3c00, 16'h1000, 16'h0000, 16'h0000, 0, -1, 16'h3c00};
      vecs[8] = '{8'd1, 16'h3c01, 16'h1000, 16'h0000, 16'h0000, 0, -1, 16'h3c02};

      reset_n        = 1'b0;
      bus.start      = 1'b0;
      bus.num_chunks = 8'd0;
      bus.in_valid   = 1'b0;
      {bus.inp0, bus.inp1, bus.inp2, bus.inp3} = '0;
      repeat (3) step();
      chk("reset in_ready", 16'(bus.in_ready), 16'd0);
      chk("reset busy", 16'(bus.busy), 16'd0);
      chk("reset sum_valid", 16'(bus.sum_valid), 16'd0);
      chk("reset sum_out", bus.sum_out, 16'h0000);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Empty vector: DONE straight from IDLE, accumulator cleared
      bus.start      = 1'b1;
      bus.num_chunks = 8'd0;
      bus.in_valid   = 1'b1;
      step();
      bus.start = 1'b0;
      chk("zero sum_valid", 16'(bus.sum_valid), 16'd1);
      chk("zero sum_out", bus.sum_out, 16'h0000);
      chk("zero in_ready", 16'(bus.in_ready), 16'd0);
      step();
      bus.in_valid = 1'b0;
      chk("zero sum_valid pulse", 16'(bus.sum_valid), 16'd0);
      chk("zero busy", 16'(bus.busy), 16'd0);
      chk("zero in_ready idle", 16'(bus.in_ready), 16'd0);

      // Reset mid-vector: abort with no result
      bus.start      = 1'b1;
      bus.num_chunks = 8'd4;
      step();
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      {bus.inp0, bus.inp1, bus.inp2, bus.inp3} = {4{16'h3c00}};
      repeat (2) step();
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("midreset in_ready", 16'(bus.in_ready), 16'd0);
      chk("midreset busy", 16'(bus.busy), 16'd0);
      chk("midreset sum_valid", 16'(bus.sum_valid), 16'd0);
      chk("midreset sum_out", bus.sum_out, 16'h0000);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("midreset no sum_valid", 16'(bus.sum_valid), 16'd0);
         chk("midreset stays idle", 16'(bus.busy), 16'd0);
      end
      bus.in_valid = 1'b0;
      v = '{8'd1, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 0, -1, 16'h4400};
      run_vec(v, "after_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
